// File: rtl/fifo_pack_8to32_pkg.sv
// Shared constants and lane helpers for the 8-to-32 DMA return-path packer.
package fifo_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int LANES  = 4;

    typedef logic [2:0] fill_t;

    // Byte lane that receives the idx-th byte of a word.
    function automatic logic [1:0] lane_of(input fill_t idx, input bit little_endian);
        return little_endian ? idx[1:0] : (2'd3 - idx[1:0]);
    endfunction

    // Lanes occupied by the first 'count' bytes of a word.
    function automatic logic [3:0] be_mask(input fill_t count, input bit little_endian);
        logic [3:0] m;
        case (count)
            3'd0:    m = 4'b0000;
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            3'd3:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return little_endian ? m : {m[0], m[1], m[2], m[3]};
    endfunction

endpackage

// File: rtl/fifo_pack_8to32_if.sv
// Byte-in / word-out handshake bundle of the packer; slave is the packer side.
interface fifo_pack_8to32_if;
    import fifo_pkg::*;

    logic [BYTE_W-1:0] data_in_8bit;
    logic              wr_byte;
    logic              byte_ready;
    logic              flush;
    logic              flush_ack;
    logic [WORD_W-1:0] data_out_32bit;
    logic [LANES-1:0]  byte_en;
    logic              word_valid;
    logic              rd_word;
    fill_t             fill_level;
    logic              err_overrun;

    modport master (
        output data_in_8bit, wr_byte, flush, rd_word,
        input  byte_ready, flush_ack, data_out_32bit, byte_en, word_valid,
               fill_level, err_overrun
    );

    modport slave (
        input  data_in_8bit, wr_byte, flush, rd_word,
        output byte_ready, flush_ack, data_out_32bit, byte_en, word_valid,
               fill_level, err_overrun
    );

endinterface

// File: rtl/fifo_pack_8to32.sv
// Packs DMA bytes into 32-bit words: one word in assembly, one held at the output.
// Flush emits a partial word with byte enables and FILL_BYTE on empty lanes.
module fifo_pack_8to32
    import fifo_pkg::*;
#(
    parameter bit              LITTLE_ENDIAN = 1'b1,
    parameter logic [BYTE_W-1:0] FILL_BYTE   = 8'h00
) (
    input logic               clk,
    input logic               reset,
    fifo_pack_8to32_if.slave  bus
);

    logic [WORD_W-1:0] asm_q;
    logic [WORD_W-1:0] out_q;
    logic [LANES-1:0]  be_q;
    logic              valid_q;
    logic              ack_q;
    logic              err_q;
    fill_t             fill_q;

    logic              out_free;
    logic              byte_ready;
    logic              accept;
    logic              full_load;
    logic              flush_svc;
    fill_t             eff;
    logic [1:0]        lane;
    logic [WORD_W-1:0] asm_next;
    logic [WORD_W-1:0] flush_word;
    logic [LANES-1:0]  flush_mask;

    assign out_free   = !valid_q || bus.rd_word;
    assign byte_ready = (fill_q != 3'd3) || out_free;
    assign accept     = bus.wr_byte && byte_ready;
    assign full_load  = accept && (fill_q == 3'd3);
    // A completing full word wins; the flush waits for a later edge.
    assign flush_svc  = bus.flush && out_free && !((fill_q == 3'd3) && bus.wr_byte);
    assign eff        = fill_q + fill_t'(accept);
    assign lane       = lane_of(fill_q, LITTLE_ENDIAN);

    always_comb begin
        asm_next   = asm_q;
        flush_word = '0;
        flush_mask = be_mask(eff, LITTLE_ENDIAN);
        for (int i = 0; i < LANES; i++) begin
            if (accept && (lane == 2'(i)))
                asm_next[i*BYTE_W +: BYTE_W] = bus.data_in_8bit;
        end
        // Stale bytes from earlier words stay in asm_q; only masked lanes pass.
        for (int i = 0; i < LANES; i++) begin
            flush_word[i*BYTE_W +: BYTE_W] = flush_mask[i] ? asm_next[i*BYTE_W +: BYTE_W]
                                                          : FILL_BYTE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_q   <= '0;
            out_q   <= '0;
            be_q    <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            fill_q  <= '0;
        end else begin
            ack_q <= flush_svc;
            if (accept)
                asm_q <= asm_next;
            if (bus.wr_byte && !byte_ready)
                err_q <= 1'b1;
            if (full_load) begin
                out_q   <= asm_next;
                be_q    <= 4'hF;
                valid_q <= 1'b1;
                fill_q  <= '0;
            end else if (flush_svc && (eff != 3'd0)) begin
                out_q   <= flush_word;
                be_q    <= flush_mask;
                valid_q <= 1'b1;
                fill_q  <= '0;
            end else begin
                if (accept)
                    fill_q <= fill_q + 3'd1;
                if (bus.rd_word && valid_q)
                    valid_q <= 1'b0;
            end
        end
    end

    assign bus.byte_ready     = byte_ready;
    assign bus.flush_ack      = ack_q;
    assign bus.data_out_32bit = out_q;
    assign bus.byte_en        = be_q;
    assign bus.word_valid     = valid_q;
    assign bus.fill_level     = fill_q;
    assign bus.err_overrun    = err_q;

endmodule

// File: tb/tb_fifo_pack_8to32.sv
// Directed bench for fifo_pack_8to32: little-endian instance plus a big-endian one.
module tb_fifo_pack_8to32;

    logic clk;
    logic reset;
    int   n_total = 0;
    int   n_bad   = 0;

    fifo_pack_8to32_if bl();
    fifo_pack_8to32_if bb();

    fifo_pack_8to32 #(.LITTLE_ENDIAN(1'b1), .FILL_BYTE(8'h00)) u_le (
        .clk(clk), .reset(reset), .bus(bl.slave));
    fifo_pack_8to32 #(.LITTLE_ENDIAN(1'b0), .FILL_BYTE(8'h00)) u_be (
        .clk(clk), .reset(reset), .bus(bb.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic le_byte(input logic [7:0] b);
        bl.wr_byte = 1'b1;
        bl.data_in_8bit = b;
        tick();
        bl.wr_byte = 1'b0;
    endtask

    task automatic be_byte(input logic [7:0] b);
        bb.wr_byte = 1'b1;
        bb.data_in_8bit = b;
        tick();
        bb.wr_byte = 1'b0;
    endtask

    initial begin
        logic [7:0] seq [4];
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
        bl.data_in_8bit = '0; bl.wr_byte = 0; bl.flush = 0; bl.rd_word = 0;
        bb.data_in_8bit = '0; bb.wr_byte = 0; bb.flush = 0; bb.rd_word = 0;
        reset = 1'b1;
        #12;
        chk("rst_valid", 32'(bl.word_valid), 32'd0);
        chk("rst_data", bl.data_out_32bit, 32'h0);
        chk("rst_be", 32'(bl.byte_en), 32'h0);
        chk("rst_fill", 32'(bl.fill_level), 32'd0);
        chk("rst_err", 32'(bl.err_overrun), 32'd0);
        chk("rst_ack", 32'(bl.flush_ack), 32'd0);
        chk("rst_ready", 32'(bl.byte_ready), 32'd1);
        reset = 1'b0;
        tick();

        // 1: LE word 44332211
        for (int i = 0; i < 4; i++) begin
            le_byte(seq[i]);
            if (i < 3) chk("t1_fill", 32'(bl.fill_level), 32'(i + 1));
        end
        chk("t1_valid", 32'(bl.word_valid), 32'd1);
        chk("t1_data", bl.data_out_32bit, 32'h44332211);
        chk("t1_be", 32'(bl.byte_en), 32'hF);
        chk("t1_fill0", 32'(bl.fill_level), 32'd0);

        // 2: backpressure with word held
        le_byte(8'h55); le_byte(8'h66); le_byte(8'h77);
        chk("t2_fill3", 32'(bl.fill_level), 32'd3);
        bl.wr_byte = 1'b1; bl.data_in_8bit = 8'h88;
        #1;
        chk("t2_ready0", 32'(bl.byte_ready), 32'd0);
        tick();
        chk("t2_err", 32'(bl.err_overrun), 32'd1);
        chk("t2_fill_kept", 32'(bl.fill_level), 32'd3);
        chk("t2_data_kept", bl.data_out_32bit, 32'h44332211);
        bl.rd_word = 1'b1;
        #1;
        chk("t2_ready_rd", 32'(bl.byte_ready), 32'd1);

        // 3: read and load on the same edge
        tick();
        bl.wr_byte = 1'b0; bl.rd_word = 1'b0;
        chk("t3_valid", 32'(bl.word_valid), 32'd1);
        chk("t3_data", bl.data_out_32bit, 32'h88776655);
        chk("t3_fill", 32'(bl.fill_level), 32'd0);

        // 4: partial flush, then empty flush
        bl.rd_word = 1'b1; tick(); bl.rd_word = 1'b0;
        chk("t4_drained", 32'(bl.word_valid), 32'd0);
        le_byte(8'hAA); le_byte(8'hBB);
        bl.flush = 1'b1; tick();
        chk("t4_ack", 32'(bl.flush_ack), 32'd1);
        chk("t4_valid", 32'(bl.word_valid), 32'd1);
        chk("t4_data", bl.data_out_32bit, 32'h0000BBAA);
        chk("t4_be", 32'(bl.byte_en), 32'h3);
        chk("t4_fill", 32'(bl.fill_level), 32'd0);
        bl.flush = 1'b0; tick();
        chk("t4_ack_pulse", 32'(bl.flush_ack), 32'd0);
        bl.flush = 1'b1; bl.rd_word = 1'b1; tick();
        bl.flush = 1'b0; bl.rd_word = 1'b0;
        chk("t4_empty_ack", 32'(bl.flush_ack), 32'd1);
        chk("t4_empty_valid", 32'(bl.word_valid), 32'd0);
        tick();
        chk("t4_empty_ack_end", 32'(bl.flush_ack), 32'd0);
        // byte presented on the servicing edge joins the flushed word
        le_byte(8'hCC);
        bl.wr_byte = 1'b1; bl.data_in_8bit = 8'hDD; bl.flush = 1'b1;
        tick();
        bl.wr_byte = 1'b0; bl.flush = 1'b0;
        chk("t4_same_edge_data", bl.data_out_32bit, 32'h0000DDCC);
        chk("t4_same_edge_be", 32'(bl.byte_en), 32'h3);

        // 5: async reset mid-cycle with fill=2, word_valid=1
        le_byte(8'h01); le_byte(8'h02);
        chk("t5_pre_fill", 32'(bl.fill_level), 32'd2);
        chk("t5_pre_valid", 32'(bl.word_valid), 32'd1);
        #2; reset = 1'b1; #1;
        chk("t5_valid", 32'(bl.word_valid), 32'd0);
        chk("t5_data", bl.data_out_32bit, 32'h0);
        chk("t5_fill", 32'(bl.fill_level), 32'd0);
        chk("t5_err", 32'(bl.err_overrun), 32'd0);
        #2; reset = 1'b0;
        tick();
        le_byte(8'hA1); le_byte(8'hB2); le_byte(8'hC3); le_byte(8'hD4);
        chk("t5_clean_data", bl.data_out_32bit, 32'hD4C3B2A1);
        chk("t5_clean_be", 32'(bl.byte_en), 32'hF);

        // 6: big-endian partial flush and full word
        be_byte(8'h11); be_byte(8'h22); be_byte(8'h33);
        bb.flush = 1'b1; tick(); bb.flush = 1'b0;
        chk("t6_ack", 32'(bb.flush_ack), 32'd1);
        chk("t6_data", bb.data_out_32bit, 32'h11223300);
        chk("t6_be", 32'(bb.byte_en), 32'hE);
        bb.rd_word = 1'b1; tick(); bb.rd_word = 1'b0;
        chk("t6_drained", 32'(bb.word_valid), 32'd0);
        for (int i = 0; i < 4; i++) be_byte(seq[i]);
        chk("t6_full_data", bb.data_out_32bit, 32'h11223344);
        chk("t6_full_be", 32'(bb.byte_en), 32'hF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
